// File: rtl/ysyx_24120013_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// reset PC, nop encoding and an alignment helper.
package ysyx_24120013_ifu_pkg;

  typedef enum logic [2:0] {
    ST_REQ      = 3'd0,
    ST_WAIT_RSP = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WAIT_NPC = 3'd3,
    ST_FAULT    = 3'd4
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24120013_ifu_reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_24120013_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset has priority over the write enable.
  always_ff @(posedge clk) begin
    if (rst)        r_q <= RESET_VAL;
    else if (i_wen) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ysyx_24120013_ifu.sv
// Instruction fetch unit: one outstanding fetch, holds the instruction
// until the decoder takes it, then waits for the next PC.
//
// state    | meaning
// ---------+-----------------------------------------------------
// REQ      | request at PC presented to memory
// WAIT_RSP | request accepted, waiting for the response
// HOLD     | instruction offered to the decoder
// WAIT_NPC | instruction taken, waiting for the next PC
// FAULT    | bus error or misaligned next PC, sticky until reset
module ysyx_24120013_ifu
  import ysyx_24120013_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  npc_valid,
  input  logic [DATA_WIDTH-1:0] npc,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_cnt
);

  ifu_state_e            r_state;
  ifu_state_e            w_state_nxt;
  logic [31:0]           r_inst;
  logic [DATA_WIDTH-1:0] r_inst_pc;
  logic [31:0]           r_fetch_cnt;
  logic [DATA_WIDTH-1:0] w_pc;
  logic                  w_inst_fire;
  logic                  w_npc_take;
  logic                  w_npc_bad;
  logic                  w_pc_wen;
  logic                  w_rsp_ok;

  assign w_inst_fire = (r_state == ST_HOLD) && inst_ready;
  // The next PC is only consumed once the current instruction has been taken.
  assign w_npc_take  = npc_valid && ((r_state == ST_WAIT_NPC) || w_inst_fire);
  assign w_npc_bad   = is_misaligned(npc[1:0]);
  assign w_pc_wen    = w_npc_take && !w_npc_bad;
  assign w_rsp_ok    = (r_state == ST_WAIT_RSP) && imem_rsp_valid && !imem_rsp_err;

  ysyx_24120013_Reg #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst   (rst),
    .i_wen (w_pc_wen),
    .i_d   (npc),
    .o_q   (w_pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_REQ:      if (imem_req_ready) w_state_nxt = ST_WAIT_RSP;
      ST_WAIT_RSP: if (imem_rsp_valid) w_state_nxt = imem_rsp_err ? ST_FAULT : ST_HOLD;
      ST_HOLD: begin
        if (inst_ready) begin
          if (npc_valid) w_state_nxt = w_npc_bad ? ST_FAULT : ST_REQ;
          else           w_state_nxt = ST_WAIT_NPC;
        end
      end
      ST_WAIT_NPC: if (npc_valid) w_state_nxt = w_npc_bad ? ST_FAULT : ST_REQ;
      ST_FAULT:    w_state_nxt = ST_FAULT;
      default:     w_state_nxt = ST_FAULT;
    endcase
  end

  // Instruction capture and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst      <= IFU_NOP;
      r_inst_pc   <= RESET_PC;
      r_fetch_cnt <= '0;
    end else begin
      if (w_rsp_ok) begin
        r_inst    <= imem_rsp_data[31:0];
        r_inst_pc <= w_pc;
      end
      if (w_inst_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign imem_req_valid = !rst && (r_state == ST_REQ);
  assign inst_valid     = !rst && (r_state == ST_HOLD);
  assign fetch_fault    = !rst && (r_state == ST_FAULT);
  assign imem_req_addr  = w_pc;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// Directed bench for the fetch unit with a scoreboard of expected
// instructions pushed when a response is driven.
module tb_ysyx_24120013_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t q_exp[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ysyx_24120013_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .fetch_fault    (fetch_fault),
    .fetch_cnt      (fetch_cnt)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait (bounded) for an offered instruction and compare against the scoreboard.
  task automatic pop_inst(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (inst_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_total++;
    assert (seen) n_pass++;
    else $error("FAIL %s_timeout observed=no_inst_valid expected=inst_valid", tag);
    if (seen && q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk({tag, "_inst"}, inst, e.ins);
      chk({tag, "_pc"}, inst_pc, e.pc);
    end
  endtask

  // Accept one request and return a good response on the following cycle.
  task automatic fetch(input logic [31:0] data, input logic [31:0] pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = 1'b0;
    q_exp.push_back('{ins: data, pc: pc});
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    npc_valid      = 1'b0;
    npc            = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);

    rst = 1'b0;
    #1;
    chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_req_addr, 32'h8000_0000);

    // Memory stalls for 5 cycles; request must stay put.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_req_addr, 32'h8000_0000);
    end

    // Accept with a stray response in the same cycle, then the real response.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    q_exp.push_back('{ins: 32'h0010_0093, pc: 32'h8000_0000});
    tick();
    imem_rsp_valid = 1'b0;
    pop_inst("first");

    // Decoder stalls 3 cycles; an npc offered meanwhile must be ignored.
    npc_valid = 1'b1;
    npc       = 32'h8000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h0010_0093);
      chk("hold_addr", imem_req_addr, 32'h8000_0000);
    end
    inst_ready = 1'b1;
    npc        = 32'h8000_0004;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
    chk("npc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("npc_addr", imem_req_addr, 32'h8000_0004);
    chk("npc_cnt", fetch_cnt, 32'd1);

    // Second fetch, handshake without npc, then misaligned npc.
    fetch(32'h0020_0113, 32'h8000_0004);
    pop_inst("second");
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wnpc_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("wnpc_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("wnpc_cnt", fetch_cnt, 32'd2);
    npc_valid = 1'b1;
    npc       = 32'h8000_0006;
    tick();
    npc_valid = 1'b0;
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_pc_kept", imem_req_addr, 32'h8000_0004);
    imem_req_ready = 1'b1;
    npc_valid      = 1'b1;
    npc            = 32'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("mis_pc_hold", imem_req_addr, 32'h8000_0004);
    end
    imem_req_ready = 1'b0;
    npc_valid      = 1'b0;

    // Reset out of FAULT, then bus error.
    rst = 1'b1;
    #1;
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_addr", imem_req_addr, 32'h8000_0000);
    chk("rst2_cnt", fetch_cnt, 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'h0000_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("err_fault", {31'd0, fetch_fault}, 32'd1);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = i[0];
      tick();
      chk("err_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("err_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("err_no_inst", {31'd0, inst_valid}, 32'd0);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;

    // Counter wrap from a forced preload.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(32'h0030_0193, 32'h8000_0000);
    pop_inst("third");
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_cnt;
    inst_ready = 1'b1;
    npc_valid  = 1'b1;
    npc        = 32'h8000_0008;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
    chk("wrap_cnt", fetch_cnt, 32'd0);
    chk("wrap_addr", imem_req_addr, 32'h8000_0008);

    // Reset while a response is outstanding; a late response must be dropped.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("midrst_addr", imem_req_addr, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    chk("stray_still_req", {31'd0, imem_req_valid}, 32'd1);
    chk("stray_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("stray_inst_nop", inst, 32'h0000_0013);
    fetch(32'h0040_0213, 32'h8000_0000);
    pop_inst("restart");
    chk("sb_empty", q_exp.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
